// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM states and timing constants for the audio playback engine
package audio_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FETCH} state_t;
   localparam int MIN_DUR     = 4;
   localparam int RAM_LATENCY = 2;
endpackage

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta modulator turning a signed sample into a 1-bit stream
//   clk, reset : clock, asynchronous active-high reset
//   sample     : signed two's-complement input level
//   dac_out    : registered bitstream whose ones density tracks the offset-binary sample
module sigma_delta_dac
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                dac_out
);
   logic [SAMPLE_W:0] acc;
   // inverting the MSB maps signed full scale onto 0..2^SAMPLE_W-1
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         acc     <= '0;
         dac_out <= 1'b0;
      end else begin
         acc     <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, ~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
         dac_out <= acc[SAMPLE_W];
      end
endmodule

// File: rtl/audio_player.sv
// audio_player: reads samples from RAM every max(adur,4) clocks and plays them through a sigma-delta DAC
//   clk, reset      : clock, asynchronous active-high reset
//   enable, restart : play enable (low pauses), pulse that rewinds the play address to 0
//   adur            : clocks per sample, sampled at each period reload
//   ram_addr/ram_rd : RAM read address and strobe; ram_data returns 2 cycles after ram_rd
//   aaddr           : zero-extended address of the next sample to fetch
//   sample/strobe   : current sample and its one-cycle update pulse
//   dac_out         : sigma-delta bitstream
module audio_player
   import audio_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int SAMPLE_W = 16,
   parameter int DUR_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                restart,
   input  logic [DUR_W-1:0]    adur,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_rd,
   input  logic [SAMPLE_W-1:0] ram_data,
   output logic [DUR_W-1:0]    aaddr,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_strobe,
   output logic                dac_out
);
   state_t                 state, state_nx;
   logic [DUR_W-1:0]       cnt, dur_m1;
   logic [ADDR_W-1:0]      addr;
   logic [RAM_LATENCY-1:0] pipe;
   logic                   rd_q, rd_nx, active;
   // restart suppresses a read that was already scheduled for this cycle
   assign ram_rd   = rd_q & ~restart;
   assign ram_addr = addr;
   assign aaddr    = DUR_W'(addr);
   always_comb begin
      active   = state != IDLE;
      dur_m1   = (adur < DUR_W'(MIN_DUR) ? DUR_W'(MIN_DUR) : adur) - DUR_W'(1);
      rd_nx    = enable & ~restart & (~active | cnt == '0);
      state_nx = ~enable ? IDLE : ~active ? RUN : (ram_rd | (|pipe[RAM_LATENCY-2:0])) ? FETCH : RUN;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   // the pipeline keeps shifting while paused so an in-flight fetch still lands
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt           <= '0;
         addr          <= '0;
         pipe          <= '0;
         rd_q          <= 1'b0;
         sample        <= '0;
         sample_strobe <= 1'b0;
      end else begin
         rd_q          <= rd_nx;
         cnt           <= (restart | rd_nx) ? dur_m1 : (active && cnt != '0) ? cnt - DUR_W'(1) : cnt;
         addr          <= restart ? '0 : addr + ADDR_W'(ram_rd);
         pipe          <= restart ? '0 : {pipe[RAM_LATENCY-2:0], ram_rd};
         sample_strobe <= pipe[RAM_LATENCY-1] & ~restart;
         if (pipe[RAM_LATENCY-1] & ~restart) sample <= ram_data;
      end
   sigma_delta_dac #(.SAMPLE_W(SAMPLE_W)) u_dac (
      .clk     (clk),
      .reset   (reset),
      .sample  (sample),
      .dac_out (dac_out)
   );
endmodule

// File: tb/tb_audio_player.sv
// tb_audio_player: scoreboard bench for audio_player with a 16-entry RAM model (ADDR_W=4)
module tb_audio_player;
   typedef struct {
      int          due;
      logic [15:0] val;
   } exp_t;
   logic        clk = 1'b0, reset, enable, restart;
   logic [31:0] adur;
   logic [3:0]  ram_addr;
   logic        ram_rd;
   logic [15:0] ram_data;
   logic [31:0] aaddr;
   logic [15:0] sample;
   logic        sample_strobe, dac_out;
   logic [15:0] ram_mem [16];
   logic [3:0]  a1, a2;
   logic        v1 = 1'b0, v2 = 1'b0;
   exp_t        q [$];
   int          cyc = 0, n_chk = 0, n_err = 0;
   int          rd_cnt = 0, last_rd = 0, last_gap = 0, ones, e, r, n;
   logic [3:0]  m_addr = 4'd0, last_addr;
   logic        p;
   audio_player #(.ADDR_W(4), .SAMPLE_W(16), .DUR_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .restart       (restart),
      .adur          (adur),
      .ram_addr      (ram_addr),
      .ram_rd        (ram_rd),
      .ram_data      (ram_data),
      .aaddr         (aaddr),
      .sample        (sample),
      .sample_strobe (sample_strobe),
      .dac_out       (dac_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // RAM drives valid data only in the cycle exactly two after the read strobe
   always @(posedge clk) begin
      a1 <= ram_addr;
      v1 <= ram_rd;
      a2 <= a1;
      v2 <= v1;
   end
   assign ram_data = v2 ? ram_mem[a2] : 16'hDEAD;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_rd(input int k);
      int target = rd_cnt + k;
      int t = 0;
      while (rd_cnt < target && t < 3000) begin
         step();
         t++;
      end
      if (rd_cnt < target) check("rd_timeout", rd_cnt, target);
   endtask
   task automatic fill(input logic [15:0] v, input logic ramp);
      for (int k = 0; k < 16; k++) ram_mem[k] = ramp ? 16'(k * 256) : v;
   endtask
   task automatic check_reset_outputs();
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_rd", ram_rd, 0);
      check("rst_aaddr", aaddr, 0);
      check("rst_sample", sample, 0);
      check("rst_strobe", sample_strobe, 0);
      check("rst_dac", dac_out, 0);
   endtask
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         m_addr = 4'd0;
      end else begin
         check("aaddr", aaddr, 32'(m_addr));
         if (sample_strobe) begin
            if (q.size() == 0) check("strobe_unexp", 32'(sample_strobe), 0);
            else begin
               check("strobe_t", cyc, q[0].due);
               check("sample", sample, 32'(q[0].val));
               q.delete(0);
            end
         end
         if (q.size() != 0 && q[0].due < cyc) begin
            check("strobe_miss", cyc, q[0].due);
            q.delete(0);
         end
         if (ram_rd) begin
            check("ram_addr", ram_addr, m_addr);
            q.push_back('{cyc + 3, ram_mem[ram_addr]});
            if (rd_cnt > 0) last_gap = cyc - last_rd;
            last_rd   = cyc;
            last_addr = ram_addr;
            rd_cnt++;
            m_addr++;
         end
         if (restart) begin
            m_addr = 4'd0;
            while (q.size() != 0 && q[q.size()-1].due > cyc) q.delete(q.size() - 1);
         end
      end
   end
   initial begin
      fill(16'h0, 1'b1);
      reset = 1'b1; enable = 1'b0; restart = 1'b0; adur = 32'd10;
      repeat (3) step();
      check_reset_outputs();
      reset = 1'b0;
      step();
      e = cyc; enable = 1'b1;
      wait_rd(1);
      check("en_lat", last_rd - e, 1);
      repeat (4) begin
         wait_rd(1);
         check("gap10", last_gap, 10);
      end
      adur = 32'd1;
      wait_rd(2); wait_rd(1);
      check("gap_adur1", last_gap, 4);
      adur = 32'd0;
      wait_rd(2); wait_rd(1);
      check("gap_adur0", last_gap, 4);
      adur = 32'd10;
      wait_rd(2);
      step(); step();
      adur = 32'd20;
      wait_rd(1);
      check("gap_cur10", last_gap, 10);
      wait_rd(1);
      check("gap_next20", last_gap, 20);
      adur = 32'd4;
      wait_rd(22);
      wait_rd(1);
      enable = 1'b0;
      n = rd_cnt;
      repeat (30) step();
      check("pause_rd", rd_cnt, n);
      check("pause_aaddr", aaddr, 32'(m_addr));
      check("pause_q", q.size(), 0);
      e = cyc; enable = 1'b1;
      wait_rd(1);
      check("reen_lat", last_rd - e, 1);
      adur = 32'd10;
      wait_rd(2);
      restart = 1'b1; r = cyc;
      step();
      restart = 1'b0;
      wait_rd(1);
      check("rst_addr", last_addr, 0);
      check("rst_gap_ge_n", 32'(last_rd - r >= 10), 1);
      repeat (4) step();
      enable = 1'b0; adur = 32'd4;
      repeat (6) step();
      fill(16'h0000, 1'b0);
      enable = 1'b1;
      wait_rd(1);
      enable = 1'b0;
      repeat (6) step();
      check("dac0_sample", sample, 16'h0000);
      p = dac_out;
      repeat (8) begin
         step();
         check("dac_alt", dac_out, !p);
         p = dac_out;
      end
      fill(16'h4000, 1'b0);
      enable = 1'b1;
      wait_rd(1);
      enable = 1'b0;
      repeat (8) step();
      ones = 0;
      repeat (65536) begin
         step();
         ones += int'(dac_out);
      end
      check("dac_ones_4000", ones, 49152);
      fill(16'h8000, 1'b0);
      enable = 1'b1;
      wait_rd(1);
      enable = 1'b0;
      repeat (8) step();
      ones = 0;
      repeat (64) begin
         step();
         ones += int'(dac_out);
      end
      check("dac_ones_8000", ones, 0);
      fill(16'h0, 1'b1);
      adur = 32'd10; enable = 1'b1;
      wait_rd(2);
      reset = 1'b1;
      #1;
      check_reset_outputs();
      step();
      reset = 1'b0;
      wait_rd(2);
      repeat (5) step();
      check("final_q", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/audio_player.md
# audio_player

Sample playback engine for the audio design. It sits directly downstream of the JTAG virtual DR and its sample RAM. The JTAG side writes samples into RAM and sets the per-sample duration. This block reads samples back at that rate, converts them to a 1-bit sigma-delta stream for the audio pin, and reports its current play address so the host can monitor fill level through the audio-address capture.

## Interface
- `ADDR_W`, 16, sample RAM address width; play address wraps at 2^ADDR_W.
- `SAMPLE_W`, 16, signed two's-complement sample width.
- `DUR_W`, 32, width of duration input and of the reported address.
- `clk`  in  1  system clock, 50 MHz. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  play enable; low = pause (address held).
- `restart`  in  1  single-cycle pulse; play address returns to 0.
- `adur`  in  DUR_W  clocks per sample; quasi-static, sampled only at period reload.
- `ram_addr`  out  ADDR_W  RAM read address.
- `ram_rd`  out  1  one-cycle read strobe.
- `ram_data`  in  SAMPLE_W  RAM read data, valid exactly 2 cycles after `ram_rd`.
- `aaddr`  out  DUR_W  play address of next sample to fetch, zero-extended.
- `sample`  out  SAMPLE_W  current sample, registered.
- `sample_strobe`  out  1  one-cycle pulse when `sample` updates.
- `dac_out`  out  1  sigma-delta bitstream.

## Operation
- FSM states:
  - `IDLE`: `enable` low.
  - `RUN`: period counter active.
  - `FETCH`: RAM latency wait, 2 cycles, tracked by pipeline bits.
- Effective duration is N = max(`adur`, 4), computed at each reload from `adur[DUR_W-1:0]`. No truncation beyond the clamp.
- `IDLE` -> `RUN` when `enable`=1.
  - Issue `ram_rd` with `ram_addr` = play address on the first `RUN` cycle.
  - Load the counter with N-1.
- In `RUN`:
  - Decrement the counter each cycle.
  - At 0: issue `ram_rd`, reload N-1.
  - Pipeline tap 2 cycles later: `sample` <= `ram_data`, `sample_strobe`=1.
  - Play address increments by 1 in the cycle after `ram_rd`, modulo 2^ADDR_W. `aaddr` follows.
- `enable` falls: go to `IDLE` next cycle.
  - An in-flight fetch still completes, so `sample`/strobe are still delivered.
  - `sample` then holds; `dac_out` keeps modulating it.
- `restart`:
  - Play address <= 0.
  - Pending pipeline bits are cleared: the in-flight sample is discarded and no strobe is issued.
  - Counter reloads N-1.
  - If `enable`=1 the next `ram_rd` is issued at counter 0, addressing 0.
  - `restart` wins over a simultaneous `ram_rd`: no read is issued that cycle.
- Sigma-delta:
  - First order; accumulator width SAMPLE_W+1.
  - Input is offset binary: `sample` with MSB inverted.
  - Each cycle, acc <= acc[SAMPLE_W-1:0] + offset; `dac_out` <= acc carry (bit SAMPLE_W).
  - Runs in all states.
- Reset values: all outputs 0; play address 0; accumulator 0; counter 0; state `IDLE`.

## Timing
- `ram_rd` at cycle t -> `ram_data` sampled at t+2 -> `sample`/`sample_strobe` visible at t+3.
- Steady state: `ram_rd` and `sample_strobe` both exactly every N cycles.
- N≥4 guarantees at most one fetch in flight.
- Enable to first `ram_rd`: 1 cycle (registered).
- `adur` change takes effect at the next reload only; the current period is never stretched or cut.
- Reset asserted mid-fetch: everything clears asynchronously; no strobe after reset release until a new `ram_rd` plus 3 cycles.

## Structure
- Package `audio_pkg`:
  - state enum (`IDLE`, `RUN`, `FETCH`).
  - `MIN_DUR`=4.
  - `RAM_LATENCY`=2.
- Sub-module `sigma_delta_dac`: parameter SAMPLE_W; ports `clk`, `reset`, `sample`, `dac_out`. Instantiated once.
- Period counter, address counter and fetch pipeline live in `audio_player`.

## Test plan
- RAM ram[k]=k*0x0100, `adur`=10, `enable`=1 -> `ram_rd` every 10 cycles; samples 0x0000, 0x0100, 0x0200…; `aaddr` 1, 2, 3…; strobe 3 cycles after each `ram_rd`.
- `adur`=1, then 0 -> strobe period 4 in both cases. Change `adur` 10→20 mid-period -> current period is 10, next is 20.
- ADDR_W=4, play past address 15 -> `ram_addr` sequence 14, 15, 0, 1; `aaddr` wraps to 0.
- Constant `sample`=0x0000 -> `dac_out` alternates 1/0 after settling. `sample`=0x4000 -> exactly 49152 ones per 65536 cycles. `sample`=0x8000 -> stream of 0.
- `restart` in cycle t+1 after `ram_rd` at t -> no strobe; next `ram_rd` after N cycles with `ram_addr`=0.
- Drop `enable` mid-fetch -> strobe still at t+3; then no `ram_rd`; `aaddr` held. Re-enable -> `ram_rd` 1 cycle later at the held address. Assert `reset` mid-run -> all outputs 0 immediately.
